fetch_next_pc: RTL
==================

Name: fetch_next_pc

Overview:
- Front-end PC generation stage that sits directly upstream of the gshare direction predictor.
- Holds the architectural fetch PC and drives it to the predictor's pc input and to the I-cache request path.
- Each cycle it combines the predictor's predict_taken with a tagged direct-mapped BTB to choose the next fetch PC.
- Backend mispredict/flush redirects override all predictions.

Parameters:
- RESET_PC, 32'h1eceb000, fetch PC loaded on reset.
- BTB_DEPTH, 64, BTB entries (power of 2).
- BTB_IDX, $clog2(BTB_DEPTH), index bits taken from pc[BTB_IDX+1:2].
- BTB_TAG, 32-BTB_IDX-2, tag bits taken from pc[31:BTB_IDX+2].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- fetch_pc  out  32  current fetch PC; also feeds gshare pc
- fetch_valid  out  1  fetch_pc is a valid request
- fetch_ready  in  1  downstream (I-cache/fetch queue) accepts fetch_pc this cycle
- predict_taken  in  1  gshare direction for fetch_pc (combinational)
- pred_taken_out  out  1  final taken decision sent with the instruction
- pred_target_out  out  32  predicted next PC sent with the instruction
- redirect_valid  in  1  backend flush/mispredict
- redirect_pc  in  32  correct PC after the redirect
- btb_upd_en  in  1  write one BTB entry (resolved taken branch/jump)
- btb_upd_pc  in  32  PC of the resolved branch
- btb_upd_target  in  32  resolved target
- btb_upd_uncond  in  1  entry is an unconditional jump (JAL)

Behaviour:
- Reset: fetch_pc=RESET_PC, fetch_valid=0, all BTB valid bits=0. pred_taken_out=0 and pred_target_out=RESET_PC+4 follow combinationally.
- Cycle after reset deasserts: fetch_valid=1 and stays 1 thereafter. Only one bubble is allowed, at each redirect.
- Lookup (combinational on fetch_pc):
  - hit = valid[idx] && tag[idx]==fetch_pc[31:BTB_IDX+2].
  - taken = hit && (uncond[idx] || predict_taken).
  - pred_target_out = taken ? target[idx] : fetch_pc+4.
  - pred_taken_out = taken.
- Advance: when fetch_valid && fetch_ready, fetch_pc <= pred_target_out on the next edge.
- Stall: when fetch_valid && !fetch_ready, fetch_pc holds and all outputs stay stable.
- Redirect has highest priority, regardless of fetch_ready:
  - fetch_pc <= redirect_pc, fetch_valid <= 0 for exactly one cycle (squash bubble), then 1.
  - A redirect arriving during the bubble cycle overrides again and produces another bubble.
- BTB write on btb_upd_en, at idx/tag of btb_upd_pc:
  - set valid, tag, target, uncond; overwrites any previous entry (no replacement policy).
- Simultaneous BTB write and lookup to the same index: lookup sees the old contents (read-before-write). The new entry is visible the next cycle.
- Simultaneous redirect and btb_upd_en: both take effect; they are independent.
- Reset mid-operation: rst overrides redirect, advance and BTB writes in the same cycle.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hfffffffc -> 0). No alignment check; pc[1:0] are passed through unmodified.
- Nothing on the BTB write path combinationally affects fetch_pc.

Decomposition:
- cpu_params package holds:
  - RESET_PC, BTB_DEPTH, BTB_IDX, BTB_TAG;
  - btb_entry_t struct {valid, tag[BTB_TAG], target[32], uncond}.
- One sub-module, btb: register array with a combinational read port and a synchronous write port. Reset clears only the valid bits.
- The PC register and next-PC mux stay in fetch_next_pc.

Test Plan:
- Reset then fetch_ready=1, BTB empty, predict_taken=0 -> fetch_pc sequence 1eceb000, 1eceb004, 1eceb008; fetch_valid=0 only in the first post-reset cycle.
- Write BTB pc=1eceb008 target=1eceb100 uncond=0; run with predict_taken=1 at 1eceb008 -> next fetch_pc=1eceb100, pred_taken_out=1. Repeat with predict_taken=0 -> next fetch_pc=1eceb00c.
- Write BTB pc=1eceb010 uncond=1 target=1eceb040, predict_taken=0 -> next fetch_pc=1eceb040. Then write pc=1eceb010+4*BTB_DEPTH (same index, new tag) -> lookup at 1eceb010 misses and the next fetch_pc is 1eceb014.
- fetch_ready=0 for 3 cycles at fetch_pc=1eceb004 -> fetch_pc holds 1eceb004. Assert redirect_valid with redirect_pc=1eceb200 while stalled -> next cycle fetch_pc=1eceb200, fetch_valid=0, then 1.
- Same-cycle BTB write and lookup at index of current fetch_pc=1eceb020 -> that cycle falls through to 1eceb024. A later fetch of 1eceb020 takes the new target.
- fetch_pc=32'hfffffffc, BTB miss, fetch_ready=1 -> next fetch_pc=32'h00000000. Assert rst concurrently with redirect_valid -> fetch_pc=RESET_PC and BTB cleared.

Source files
------------

// File: rtl/fetch_next_pc_pkg.sv
// Shared front-end parameters and the BTB entry layout used by the fetch PC
// generator and its branch target buffer.
package cpu_params;

  localparam logic [31:0] RESET_PC  = 32'h1eceb000;
  localparam int          BTB_DEPTH = 64;
  localparam int          BTB_IDX   = $clog2(BTB_DEPTH);
  localparam int          BTB_TAG   = 32 - BTB_IDX - 2;

  typedef struct packed {
    logic               valid;
    logic [BTB_TAG-1:0] tag;
    logic [31:0]        target;
    logic               uncond;
  } btb_entry_t;

  // Instructions are word-aligned, so pc[1:0] never takes part in indexing.
  function automatic logic [BTB_IDX-1:0] btb_index(input logic [31:0] pc);
    return pc[BTB_IDX+1:2];
  endfunction

  function automatic logic [BTB_TAG-1:0] btb_tag(input logic [31:0] pc);
    return pc[31:BTB_IDX+2];
  endfunction

endpackage

// File: rtl/fetch_next_pc_btb.sv
// Tagged direct-mapped branch target buffer: combinational lookup port and
// synchronous write port. Reset clears only the valid bits.
module btb
  import cpu_params::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic        rd_uncond,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target,
  input  logic        wr_uncond
);

  btb_entry_t mem [BTB_DEPTH];
  btb_entry_t rd_entry;
  btb_entry_t wr_entry;

  always_comb begin
    wr_entry        = '0;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = btb_tag(wr_pc);
    wr_entry.target = wr_target;
    wr_entry.uncond = wr_uncond;
  end

  // The read below samples mem before this edge lands, so a same-cycle write
  // to the looked-up index becomes visible only on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      mem[btb_index(wr_pc)] <= wr_entry;
    end
  end

  always_comb begin
    rd_entry  = mem[btb_index(rd_pc)];
    rd_hit    = rd_entry.valid && (rd_entry.tag == btb_tag(rd_pc));
    rd_uncond = rd_entry.uncond;
    rd_target = rd_entry.target;
  end

endmodule

// File: rtl/fetch_next_pc.sv
// Fetch PC register and next-PC selection: combines the gshare direction with
// a BTB lookup and lets backend redirects override every prediction.
module fetch_next_pc
  import cpu_params::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  input  logic        predict_taken,
  output logic        pred_taken_out,
  output logic [31:0] pred_target_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        btb_upd_en,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_uncond
);

  // Handshake: fetch_pc is transferred on an edge where fetch_valid and
  // fetch_ready are both high; while fetch_valid is high and fetch_ready low,
  // fetch_pc and the prediction outputs hold. fetch_valid never drops except
  // for the single squash bubble after reset or a redirect.

  logic        btb_hit;
  logic        btb_uncond;
  logic [31:0] btb_target;
  logic        taken;
  logic [31:0] seq_pc;
  logic        advance;

  btb u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (fetch_pc),
    .rd_hit    (btb_hit),
    .rd_uncond (btb_uncond),
    .rd_target (btb_target),
    .wr_en     (btb_upd_en),
    .wr_pc     (btb_upd_pc),
    .wr_target (btb_upd_target),
    .wr_uncond (btb_upd_uncond)
  );

  always_comb begin
    seq_pc          = fetch_pc + 32'd4;
    taken           = btb_hit && (btb_uncond || predict_taken);
    pred_taken_out  = taken;
    pred_target_out = taken ? btb_target : seq_pc;
    advance         = fetch_valid && fetch_ready;
  end

  // Priority: reset, then redirect, then advance. A bubble cycle never
  // advances; it only re-arms fetch_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      fetch_valid <= 1'b0;
    end else begin
      if (advance) begin
        fetch_pc <= pred_target_out;
      end
      fetch_valid <= 1'b1;
    end
  end

endmodule
